// File: rtl/fpaddsub_pkg.sv
// fpaddsub_pkg: default widths and shift-count width helper for the normalize pipeline
package fpaddsub_pkg;
  localparam int MW_DEF = 17;
  localparam int EW_DEF = 5;
  function automatic int shift_width(input int mw);
    return $clog2(mw + 1);
  endfunction
endpackage

// File: rtl/fpaddsub_lzc.sv
// fpaddsub_lzc: combinational leading-zero count, returns MW for an all-zero input
module fpaddsub_lzc
  import fpaddsub_pkg::*;
#(
  parameter int MW = MW_DEF,
  parameter int SW = shift_width(MW)
) (
  input  logic [MW-1:0] i_data,
  output logic [SW-1:0] o_lzc
);
  always_comb begin
    o_lzc = SW'(MW);
    for (int i = 0; i < MW; i++)
      if (i_data[i]) o_lzc = SW'(MW - 1 - i);
  end
endmodule

// File: rtl/fpaddsub_normalize_pipe.sv
// fpaddsub_normalize_pipe: two-stage valid/ready pipeline that left-normalizes an add/sub mantissa sum
module fpaddsub_normalize_pipe
  import fpaddsub_pkg::*;
#(
  parameter int MW = MW_DEF,
  parameter int EW = EW_DEF,
  parameter int SW = shift_width(MW)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [MW-1:0] in_sum,
  input  logic [EW-1:0] in_exp,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [MW-1:0] out_mant,
  output logic [SW-1:0] out_shift,
  output logic [EW-1:0] out_exp,
  output logic          out_zero,
  output logic          out_uflow
);
  localparam int XW = (SW > EW ? SW : EW) + 1;
  logic          r1_valid, r2_valid, r2_zero, r2_uflow;
  logic [MW-1:0] r1_sum, r2_mant;
  logic [EW-1:0] r1_exp, r2_exp;
  logic [SW-1:0] r1_lzc, r2_shift;
  logic          w_s1_adv, w_s2_adv, w_take, w_zero, w_clip;
  logic [SW-1:0] w_lzc, w_sh;
  logic [MW-1:0] w_mant;
  fpaddsub_lzc #(.MW(MW), .SW(SW)) u_lzc (.i_data(in_sum), .o_lzc(w_lzc));
  assign w_s2_adv = !r2_valid || out_ready;
  assign w_s1_adv = !r1_valid || w_s2_adv;
  assign in_ready = !rst && w_s1_adv;
  assign w_take   = in_valid && in_ready;
  assign w_zero   = r1_sum == '0;
  // Shift is capped by the exponent; the excess becomes a denormal (uflow) result
  assign w_clip   = XW'(r1_lzc) > XW'(r1_exp);
  assign w_sh     = w_zero ? '0 : w_clip ? SW'(r1_exp) : r1_lzc;
  always_comb begin
    w_mant = r1_sum;
    for (int k = 0; k < SW; k++) w_mant = w_sh[k] ? w_mant << (1 << k) : w_mant;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r1_valid <= 1'b0;
      r2_valid <= 1'b0;
      r2_mant  <= '0;
      r2_shift <= '0;
      r2_exp   <= '0;
      r2_zero  <= 1'b0;
      r2_uflow <= 1'b0;
    end else begin
      if (w_s1_adv) r1_valid <= w_take;
      if (w_take) begin
        r1_sum <= in_sum;
        r1_exp <= in_exp;
        r1_lzc <= w_lzc;
      end
      if (w_s2_adv) begin
        r2_valid <= r1_valid;
        if (r1_valid) begin
          r2_mant  <= w_mant;
          r2_shift <= w_sh;
          r2_exp   <= w_zero ? '0 : r1_exp - EW'(w_sh);
          r2_zero  <= w_zero;
          r2_uflow <= !w_zero && w_clip;
        end
      end
    end
  end
  assign out_valid = r2_valid;
  assign out_mant  = r2_mant;
  assign out_shift = r2_shift;
  assign out_exp   = r2_exp;
  assign out_zero  = r2_zero;
  assign out_uflow = r2_uflow;
endmodule

// File: tb/tb_fpaddsub_normalize_pipe.sv
// tb_fpaddsub_normalize_pipe: directed and random checks of the normalize pipeline (MW=17, EW=5)
module tb_fpaddsub_normalize_pipe;
  logic        clk = 0, rst = 1, in_valid = 0, in_ready, out_valid, out_ready = 1;
  logic        out_zero, out_uflow;
  logic [16:0] in_sum = '0, out_mant;
  logic [4:0]  in_exp = '0, out_exp, out_shift;
  logic [28:0] got;
  int          checks = 0, failures = 0;
  logic [16:0] bb_sum [5] = '{17'h10000, 17'h00010, 17'h00001, 17'h00000, 17'h0C000};
  logic [4:0]  bb_e   [5] = '{5'd15, 5'd20, 5'd3, 5'd9, 5'd1};
  logic [28:0] bb_exp [5] = '{{17'h10000, 5'd0, 5'd15, 1'b0, 1'b0},
                              {17'h10000, 5'd12, 5'd8, 1'b0, 1'b0},
                              {17'h00008, 5'd3, 5'd0, 1'b0, 1'b1},
                              {17'h00000, 5'd0, 5'd0, 1'b1, 1'b0},
                              {17'h18000, 5'd1, 5'd0, 1'b0, 1'b0}};
  fpaddsub_normalize_pipe #(.MW(17), .EW(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_sum(in_sum),
    .in_exp(in_exp), .out_valid(out_valid), .out_ready(out_ready), .out_mant(out_mant),
    .out_shift(out_shift), .out_exp(out_exp), .out_zero(out_zero), .out_uflow(out_uflow)
  );
  assign got = {out_mant, out_shift, out_exp, out_zero, out_uflow};
  always #5 clk = ~clk;
  function automatic logic [28:0] model(input logic [16:0] s, input logic [4:0] e);
    int lz = 0;
    int sh;
    if (s == 0) return {17'd0, 5'd0, 5'd0, 1'b1, 1'b0};
    while (!s[16-lz]) lz++;
    sh = (lz < int'(e)) ? lz : int'(e);
    return {17'(s << sh), 5'(sh), 5'(int'(e) - sh), 1'b0, lz > int'(e)};
  endfunction
  task automatic drive1(input logic [16:0] s, input logic [4:0] e);
    @(negedge clk);
    in_valid = 1; in_sum = s; in_exp = e; out_ready = 1;
    @(negedge clk);
    in_valid = 0;
  endtask
  task automatic test_reset();
    rst = 1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++; if (got !== '0) begin failures++; $display("FAIL reset_fields got=%h want=0", got); end
    rst = 0;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_release_ready got=%b want=1", in_ready); end
  endtask
  task automatic test_normalized();
    drive1(17'h10000, 5'd15);
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL latency_early got=%b want=0", out_valid); end
    @(negedge clk); #1;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL latency_valid got=%b want=1", out_valid); end
    checks++; if (got !== {17'h10000, 5'd0, 5'd15, 1'b0, 1'b0}) begin failures++; $display("FAIL normalized got=%h want=%h", got, {17'h10000, 5'd0, 5'd15, 1'b0, 1'b0}); end
  endtask
  task automatic test_shift();
    drive1(17'h00010, 5'd20);
    @(negedge clk); #1;
    checks++; if (got !== {17'h10000, 5'd12, 5'd8, 1'b0, 1'b0}) begin failures++; $display("FAIL shift12 got=%h want=%h", got, {17'h10000, 5'd12, 5'd8, 1'b0, 1'b0}); end
    drive1(17'h00010, 5'd12);
    @(negedge clk); #1;
    checks++; if (got !== {17'h10000, 5'd12, 5'd0, 1'b0, 1'b0}) begin failures++; $display("FAIL shift_eq_exp got=%h want=%h", got, {17'h10000, 5'd12, 5'd0, 1'b0, 1'b0}); end
    drive1(17'h0C000, 5'd0);
    @(negedge clk); #1;
    checks++; if (got !== {17'h0C000, 5'd0, 5'd0, 1'b0, 1'b1}) begin failures++; $display("FAIL exp0_uflow got=%h want=%h", got, {17'h0C000, 5'd0, 5'd0, 1'b0, 1'b1}); end
  endtask
  task automatic test_uflow_zero();
    drive1(17'h00001, 5'd3);
    @(negedge clk); #1;
    checks++; if (got !== {17'h00008, 5'd3, 5'd0, 1'b0, 1'b1}) begin failures++; $display("FAIL uflow got=%h want=%h", got, {17'h00008, 5'd3, 5'd0, 1'b0, 1'b1}); end
    drive1(17'h00000, 5'd9);
    @(negedge clk); #1;
    checks++; if (got !== {17'h00000, 5'd0, 5'd0, 1'b1, 1'b0}) begin failures++; $display("FAIL zero got=%h want=%h", got, {17'h00000, 5'd0, 5'd0, 1'b1, 1'b0}); end
  endtask
  task automatic test_back_to_back();
    int sent = 0, rcv = 0, extra = 0;
    bit blocked = 0, stalled = 0;
    logic [28:0] held = '0;
    for (int c = 1; c <= 30 && rcv < 5; c++) begin
      @(negedge clk);
      out_ready = !(c >= 3 && c <= 5);
      in_valid = sent < 5;
      if (sent < 5) begin in_sum = bb_sum[sent]; in_exp = bb_e[sent]; end
      #1;
      if (stalled) begin
        checks++; if (got !== held) begin failures++; $display("FAIL b2b_stable got=%h want=%h", got, held); end
      end
      if (in_valid && !in_ready) blocked = 1;
      if (out_valid && out_ready) begin
        checks++; if (got !== bb_exp[rcv]) begin failures++; $display("FAIL b2b_result%0d got=%h want=%h", rcv, got, bb_exp[rcv]); end
        rcv++;
      end
      stalled = out_valid && !out_ready;
      held = got;
      if (in_valid && in_ready) sent++;
    end
    in_valid = 0; out_ready = 1;
    repeat (4) begin @(negedge clk); #1; if (out_valid) extra++; end
    checks++; if (rcv !== 5) begin failures++; $display("FAIL b2b_count got=%0d want=5", rcv); end
    checks++; if (!blocked) begin failures++; $display("FAIL b2b_backpressure got=0 want=1"); end
    checks++; if (extra !== 0) begin failures++; $display("FAIL b2b_duplicate got=%0d want=0", extra); end
  endtask
  task automatic test_reset_midflight();
    int stale = 0;
    @(negedge clk);
    in_valid = 1; out_ready = 0; in_sum = 17'h00010; in_exp = 5'd20;
    @(negedge clk);
    in_sum = 17'h00001; in_exp = 5'd3;
    @(negedge clk);
    in_valid = 0; #1;
    checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin failures++; $display("FAIL midflight_full got=%b%b want=10", out_valid, in_ready); end
    rst = 1;
    @(negedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midflight_flush got=%b want=0", out_valid); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL midflight_rst_ready got=%b want=0", in_ready); end
    rst = 0; out_ready = 1; #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL midflight_ready got=%b want=1", in_ready); end
    repeat (5) begin @(negedge clk); #1; if (out_valid) stale++; end
    checks++; if (stale !== 0) begin failures++; $display("FAIL midflight_stale got=%0d want=0", stale); end
  endtask
  task automatic test_random();
    logic [28:0] q[$];
    logic [28:0] held = '0;
    int n = 0, cyc = 0;
    bit stalled = 0;
    while (n < 10000 && cyc < 60000) begin
      @(negedge clk);
      cyc++;
      in_valid = $urandom_range(0, 9) < 8;
      out_ready = $urandom_range(0, 3) != 0;
      in_sum = 17'($urandom) >> $urandom_range(0, 17);
      in_exp = 5'($urandom);
      #1;
      if (stalled) begin
        checks++; if (got !== held) begin failures++; $display("FAIL rand_stable got=%h want=%h", got, held); end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin failures++; $display("FAIL rand_spurious got=%h want=none", got); end
        else begin
          if (got !== q[0]) begin failures++; $display("FAIL rand_result%0d got=%h want=%h", n, got, q[0]); end
          void'(q.pop_front());
        end
        n++;
      end
      stalled = out_valid && !out_ready;
      held = got;
      if (in_valid && in_ready) q.push_back(model(in_sum, in_exp));
    end
    in_valid = 0; out_ready = 1;
    checks++; if (n !== 10000) begin failures++; $display("FAIL rand_timeout got=%0d want=10000", n); end
    repeat (4) @(negedge clk);
  endtask
  initial begin
    test_reset();
    test_normalized();
    test_shift();
    test_uflow_zero();
    test_back_to_back();
    test_reset_midflight();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
